// File: rtl/stream_frame_gate.sv
`default_nettype none
// ============================================================================
// Module   : stream_frame_gate
// Purpose  : Whole-frame pass/drop gate for the synchronised pixel stream
//            (clk_pix domain). The pass/drop decision is taken once per frame,
//            at the fval rising edge, from stream-enable & acquisition-start &
//            encrypt-state. Frames are never truncated or started mid-frame.
//            Outputs are registered with exactly one enabled cycle of latency.
// Optional : FRAME_GATE_STAT_EN - builds the passed/dropped frame counters;
//            when undefined both counter ports are tied to zero.
// Ports    : clk_pix / reset_pix_n   clock, asynchronous active-low reset
//            i_clk_en                clock enable, all state holds when 0
//            i_fval/i_lval/iv_pix_data  input stream from the sync buffer
//            i_stream_enable, i_acquisition_start, i_encrypt_state  gate terms
//            o_fval/o_lval/ov_pix_data  gated stream (1-cycle latency)
//            o_frame_active          high while a passed frame is in flight
//            ov_frame_cnt/ov_drop_cnt  passed / dropped frame counters
// Revision : 1.0 - initial release
// ============================================================================
module stream_frame_gate #(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32
) (
  input  logic                                   clk_pix,
  input  logic                                   reset_pix_n,
  input  logic                                   i_clk_en,
  input  logic                                   i_fval,
  input  logic                                   i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                                   i_stream_enable,
  input  logic                                   i_acquisition_start,
  input  logic                                   i_encrypt_state,
  output logic                                   o_fval,
  output logic                                   o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                                   o_frame_active,
  output logic [REG_WD-1:0]                      ov_frame_cnt,
  output logic [REG_WD-1:0]                      ov_drop_cnt
);

  localparam int PIX_WD = SENSOR_DAT_WIDTH * CHANNEL_NUM;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_fval_d1;
  logic                w_rise;
  logic                w_fall;
  logic                w_en;
  logic                w_pass;
  logic                w_lval_gated;
  logic                r_fval;
  logic                r_lval;
  logic [PIX_WD-1:0]   r_pix_data;
  logic                r_frame_active;

  assign w_rise = i_fval & ~r_fval_d1;
  assign w_fall = ~i_fval & r_fval_d1;
  assign w_en   = i_stream_enable & i_acquisition_start & i_encrypt_state;

  // The gate terms are only looked at in IDLE on a rise, so changes to them
  // while a frame is in flight can never cut or open that frame.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_next_state = w_en ? S_PASS : S_DROP;
        end
      end
      S_PASS, S_DROP: begin
        if (w_fall) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Gating on next_state lets the first fval cycle of a passed frame through
  // in the rise cycle itself, keeping the output a pure 1-cycle delay.
  assign w_pass       = (w_next_state == S_PASS);
  assign w_lval_gated = i_lval & i_fval & w_pass;

  // fval_d1 resets to 1 so a frame already high at reset release is not seen
  // as a rise; the remainder of that frame is ignored.
  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      r_state        <= S_IDLE;
      r_fval_d1      <= 1'b1;
      r_fval         <= 1'b0;
      r_lval         <= 1'b0;
      r_pix_data     <= '0;
      r_frame_active <= 1'b0;
    end else if (i_clk_en) begin
      r_state        <= w_next_state;
      r_fval_d1      <= i_fval;
      r_fval         <= i_fval & w_pass;
      r_lval         <= w_lval_gated;
      r_pix_data     <= w_lval_gated ? iv_pix_data : '0;
      r_frame_active <= w_pass;
    end
  end

  assign o_fval         = r_fval;
  assign o_lval         = r_lval;
  assign ov_pix_data    = r_pix_data;
  assign o_frame_active = r_frame_active;

`ifdef FRAME_GATE_STAT_EN
  logic [REG_WD-1:0] r_frame_cnt;
  logic [REG_WD-1:0] r_drop_cnt;

  // Counters wrap naturally modulo 2^REG_WD.
  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else if (i_clk_en && (r_state == S_IDLE)) begin
      if (w_next_state == S_PASS) begin
        r_frame_cnt <= r_frame_cnt + REG_WD'(1);
      end
      if (w_next_state == S_DROP) begin
        r_drop_cnt <= r_drop_cnt + REG_WD'(1);
      end
    end
  end

  assign ov_frame_cnt = r_frame_cnt;
  assign ov_drop_cnt  = r_drop_cnt;
`else
  assign ov_frame_cnt = '0;
  assign ov_drop_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_frame_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_frame_gate
// Purpose  : Directed self-checking bench for stream_frame_gate. Frames are
//            4 lines x 8 pixels with 2-cycle hblank and 3-cycle vblank; each
//            frame therefore has 41 fval-high cycles and 32 lval cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_frame_gate;

  localparam int W  = 40;
  localparam int RW = 32;
  localparam int FRAME_FV = 41;
  localparam int FRAME_LV = 32;

  logic          clk_pix = 1'b0;
  logic          reset_pix_n = 1'b0;
  logic          i_clk_en = 1'b1;
  logic          i_fval = 1'b0;
  logic          i_lval = 1'b0;
  logic [W-1:0]  iv_pix_data = '0;
  logic          i_stream_enable = 1'b1;
  logic          i_acquisition_start = 1'b1;
  logic          i_encrypt_state = 1'b1;
  logic          o_fval;
  logic          o_lval;
  logic [W-1:0]  ov_pix_data;
  logic          o_frame_active;
  logic [RW-1:0] ov_frame_cnt;
  logic [RW-1:0] ov_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // per-frame observations gathered by run_frame
  int m_fval, m_lval, m_lines, m_pulses, m_act, m_bad, m_hold;
  logic pf, pl;
  bit g_toggle = 1'b0;

  stream_frame_gate #(
    .SENSOR_DAT_WIDTH(10),
    .CHANNEL_NUM     (4),
    .REG_WD          (RW)
  ) dut (
    .clk_pix            (clk_pix),
    .reset_pix_n        (reset_pix_n),
    .i_clk_en           (i_clk_en),
    .i_fval             (i_fval),
    .i_lval             (i_lval),
    .iv_pix_data        (iv_pix_data),
    .i_stream_enable    (i_stream_enable),
    .i_acquisition_start(i_acquisition_start),
    .i_encrypt_state    (i_encrypt_state),
    .o_fval             (o_fval),
    .o_lval             (o_lval),
    .ov_pix_data        (ov_pix_data),
    .o_frame_active     (o_frame_active),
    .ov_frame_cnt       (ov_frame_cnt),
    .ov_drop_cnt        (ov_drop_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // One enabled cycle; optionally followed by a disabled cycle with scrambled inputs.
  task automatic cyc(input logic f, input logic l);
    logic [W-1:0]  d;
    logic          so_f, so_l, so_a;
    logic [W-1:0]  so_d;
    logic [RW-1:0] so_fc, so_dc;
    d = W'({$urandom(), $urandom()});
    i_clk_en = 1'b1;
    i_fval = f;
    i_lval = l;
    iv_pix_data = d;
    tick();
    if (o_fval && !pf) m_pulses++;
    if (o_lval && !pl) m_lines++;
    pf = o_fval;
    pl = o_lval;
    if (o_fval) m_fval++;
    if (o_lval) m_lval++;
    if (o_frame_active) m_act++;
    if (o_lval && !o_fval) m_bad++;
    if (!o_lval && ov_pix_data !== '0) m_bad++;
    if (o_fval && (f !== 1'b1 || o_lval !== (f & l) || (o_lval && ov_pix_data !== d))) m_bad++;
    if (g_toggle) begin
      so_f = o_fval; so_l = o_lval; so_d = ov_pix_data; so_a = o_frame_active;
      so_fc = ov_frame_cnt; so_dc = ov_drop_cnt;
      i_clk_en = 1'b0;
      i_fval = ~f;
      i_lval = ~l;
      iv_pix_data = ~d;
      tick();
      if (o_fval !== so_f || o_lval !== so_l || ov_pix_data !== so_d ||
          o_frame_active !== so_a || ov_frame_cnt !== so_fc || ov_drop_cnt !== so_dc)
        m_hold++;
      i_clk_en = 1'b1;
    end
  endtask

  task automatic run_frame(input int se_line, input logic se_val);
    m_fval = 0; m_lval = 0; m_lines = 0; m_pulses = 0; m_act = 0; m_bad = 0; m_hold = 0;
    pf = 1'b0; pl = 1'b0;
    cyc(1'b1, 1'b0);
    for (int ln = 0; ln < 4; ln++) begin
      if (ln == se_line) i_stream_enable = se_val;
      for (int c = 0; c < 8; c++) cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_fval = 1'b0; i_lval = 1'b0; i_clk_en = 1'b1;
    reset_pix_n = 1'b0;
    tick(); tick();
    reset_pix_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_pix_n = 1'b0;
    i_fval = 1'b1; i_lval = 1'b1; iv_pix_data = '1;
    repeat (3) tick();
    n_cmp++; if (o_fval !== 1'b0) begin n_err++; $display("FAIL reset_o_fval: got %b want 0", o_fval); end
    n_cmp++; if (o_lval !== 1'b0) begin n_err++; $display("FAIL reset_o_lval: got %b want 0", o_lval); end
    n_cmp++; if (ov_pix_data !== '0) begin n_err++; $display("FAIL reset_pix: got %h want 0", ov_pix_data); end
    n_cmp++; if (o_frame_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", o_frame_active); end
    n_cmp++; if (ov_frame_cnt !== '0 || ov_drop_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", ov_frame_cnt, ov_drop_cnt); end
    i_fval = 1'b0; i_lval = 1'b0; iv_pix_data = '0;
    tick();
    reset_pix_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_pass();
    int s_fv, s_lv, s_ln, s_pu, s_bad, s_act;
    s_fv = 0; s_lv = 0; s_ln = 0; s_pu = 0; s_bad = 0; s_act = 0;
    for (int k = 0; k < 30; k++) begin
      run_frame(-1, 1'b1);
      s_fv += m_fval; s_lv += m_lval; s_ln += m_lines; s_pu += m_pulses; s_bad += m_bad; s_act += m_act;
    end
    n_cmp++; if (s_pu != 30) begin n_err++; $display("FAIL pass_pulses: got %0d want 30", s_pu); end
    n_cmp++; if (s_fv != 30*FRAME_FV) begin n_err++; $display("FAIL pass_fval_cycles: got %0d want %0d", s_fv, 30*FRAME_FV); end
    n_cmp++; if (s_lv != 30*FRAME_LV) begin n_err++; $display("FAIL pass_lval_cycles: got %0d want %0d", s_lv, 30*FRAME_LV); end
    n_cmp++; if (s_ln != 120) begin n_err++; $display("FAIL pass_lines: got %0d want 120", s_ln); end
    n_cmp++; if (s_bad != 0) begin n_err++; $display("FAIL pass_bitexact: got %0d bad cycles want 0", s_bad); end
    n_cmp++; if (s_act != 30*FRAME_FV) begin n_err++; $display("FAIL pass_active: got %0d want %0d", s_act, 30*FRAME_FV); end
  endtask

  task automatic test_se_drop();
    int s_drop_fv;
    s_drop_fv = 0;
    i_stream_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_frame((k == 5) ? 2 : -1, 1'b0);
      if (k == 5) begin
        n_cmp++; if (m_lines != 4 || m_lval != FRAME_LV || m_fval != FRAME_FV || m_bad != 0) begin
          n_err++; $display("FAIL se_drop_frame5: got lines=%0d lv=%0d fv=%0d bad=%0d want 4/%0d/%0d/0",
                            m_lines, m_lval, m_fval, m_bad, FRAME_LV, FRAME_FV);
        end
      end
      if (k > 5) s_drop_fv += m_fval + m_lval + m_act;
    end
    n_cmp++; if (s_drop_fv != 0) begin n_err++; $display("FAIL se_drop_later: got %0d active cycles want 0", s_drop_fv); end
    i_stream_enable = 1'b1;
  endtask

  task automatic test_se_rise();
    i_stream_enable = 1'b0;
    run_frame(2, 1'b1);
    n_cmp++; if (m_fval != 0 || m_act != 0) begin n_err++; $display("FAIL se_rise_dropped: got fv=%0d act=%0d want 0/0", m_fval, m_act); end
    run_frame(-1, 1'b1);
    n_cmp++; if (m_lines != 4 || m_fval != FRAME_FV || m_bad != 0) begin
      n_err++; $display("FAIL se_rise_next: got lines=%0d fv=%0d bad=%0d want 4/%0d/0", m_lines, m_fval, m_bad, FRAME_FV);
    end
    i_acquisition_start = 1'b0;
    run_frame(-1, 1'b1);
    n_cmp++; if (m_fval != 0) begin n_err++; $display("FAIL acq_low_drop: got fv=%0d want 0", m_fval); end
    i_acquisition_start = 1'b1;
    i_encrypt_state = 1'b0;
    run_frame(-1, 1'b1);
    n_cmp++; if (m_fval != 0) begin n_err++; $display("FAIL enc_low_drop: got fv=%0d want 0", m_fval); end
    i_encrypt_state = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int hi;
    hi = 0;
    i_fval = 1'b1; i_lval = 1'b0; tick();
    i_lval = 1'b1; repeat (3) tick();
    n_cmp++; if (o_fval !== 1'b1) begin n_err++; $display("FAIL midrst_pre_fval: got %b want 1", o_fval); end
    #2 reset_pix_n = 1'b0;
    #1;
    n_cmp++; if (o_fval !== 1'b0 || o_lval !== 1'b0 || ov_pix_data !== '0 || o_frame_active !== 1'b0) begin
      n_err++; $display("FAIL midrst_async_clear: got fv=%b lv=%b pix=%h act=%b want 0", o_fval, o_lval, ov_pix_data, o_frame_active);
    end
    tick(); tick();
    reset_pix_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_lval = i[0];
      tick();
      if (o_fval || o_lval || o_frame_active) hi++;
    end
    n_cmp++; if (hi != 0) begin n_err++; $display("FAIL midrst_rest_ignored: got %0d active cycles want 0", hi); end
    i_fval = 1'b0; i_lval = 1'b0;
    tick(); tick();
    run_frame(-1, 1'b1);
    n_cmp++; if (m_lines != 4 || m_fval != FRAME_FV || m_bad != 0) begin
      n_err++; $display("FAIL midrst_next_frame: got lines=%0d fv=%0d bad=%0d want 4/%0d/0", m_lines, m_fval, m_bad, FRAME_FV);
    end
  endtask

  task automatic test_short_pulses();
    logic         fv [12];
    logic         lv [12];
    logic [W-1:0] d;
    fv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    lv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      d = W'({$urandom(), $urandom()});
      i_fval = fv[i]; i_lval = lv[i]; iv_pix_data = d;
      tick();
      n_cmp++; if (o_fval !== fv[i]) begin n_err++; $display("FAIL short_fval[%0d]: got %b want %b", i, o_fval, fv[i]); end
      n_cmp++; if (o_lval !== (fv[i] & lv[i])) begin n_err++; $display("FAIL short_lval[%0d]: got %b want %b", i, o_lval, fv[i] & lv[i]); end
      n_cmp++; if (ov_pix_data !== ((fv[i] & lv[i]) ? d : '0)) begin n_err++; $display("FAIL short_pix[%0d]: got %h want %h", i, ov_pix_data, (fv[i] & lv[i]) ? d : '0); end
    end
    i_stream_enable = 1'b0;
    i_fval = 1'b1; i_lval = 1'b1; tick();
    n_cmp++; if (o_fval !== 1'b0 || o_lval !== 1'b0) begin n_err++; $display("FAIL short_en0_pulse: got fv=%b lv=%b want 0/0", o_fval, o_lval); end
    i_fval = 1'b0; i_lval = 1'b0; tick(); tick();
    i_stream_enable = 1'b1;
  endtask

  task automatic test_clk_en_stats();
    int s_pu, s_hold, s_bad;
    s_pu = 0; s_hold = 0; s_bad = 0;
    do_reset();
    g_toggle = 1'b1;
    for (int k = 0; k < 30; k++) begin
      i_stream_enable = (k >= 10 && k <= 14) ? 1'b0 : 1'b1;
      run_frame(-1, 1'b1);
      s_pu += m_pulses; s_hold += m_hold; s_bad += m_bad;
    end
    g_toggle = 1'b0;
    i_stream_enable = 1'b1;
    n_cmp++; if (s_pu != 25) begin n_err++; $display("FAIL clken_pulses: got %0d want 25", s_pu); end
    n_cmp++; if (s_hold != 0) begin n_err++; $display("FAIL clken_hold: got %0d changed cycles want 0", s_hold); end
    n_cmp++; if (s_bad != 0) begin n_err++; $display("FAIL clken_bitexact: got %0d bad cycles want 0", s_bad); end
`ifdef FRAME_GATE_STAT_EN
    n_cmp++; if (ov_frame_cnt !== RW'(25)) begin n_err++; $display("FAIL stat_frame_cnt: got %0d want 25", ov_frame_cnt); end
    n_cmp++; if (ov_drop_cnt !== RW'(5)) begin n_err++; $display("FAIL stat_drop_cnt: got %0d want 5", ov_drop_cnt); end
`else
    n_cmp++; if (ov_frame_cnt !== '0) begin n_err++; $display("FAIL stat_frame_cnt_tied: got %0d want 0", ov_frame_cnt); end
    n_cmp++; if (ov_drop_cnt !== '0) begin n_err++; $display("FAIL stat_drop_cnt_tied: got %0d want 0", ov_drop_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_pass();
    test_se_drop();
    test_se_rise();
    test_reset_mid_frame();
    test_short_pulses();
    test_clk_en_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
